if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk_i  input  1  the single clock; all state updates occur on the rising edge.
REQ-003 The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port stall_i  input  1  decode-side hold; while high with valid_o high, the output registers hold.
REQ-005 The block SHALL have port redirect_i  input  1  taken branch/jump; kills in-flight fetches.
REQ-006 The block SHALL have port redirect_pc_i  input  32  new fetch address; bits [1:0] ignored and stored as 0.
REQ-007 The block SHALL have port imem_req_o  output  1  instruction memory request.
REQ-008 The block SHALL have port imem_addr_o  output  32  request address, word aligned.
REQ-009 The block SHALL have port imem_ack_i  input  1  response valid; may arrive in the same cycle as req or any later cycle.
REQ-010 The block SHALL have port imem_rdata_i  input  32  instruction word, valid with imem_ack_i.
REQ-011 The block SHALL have ports pc_o, pcplus4_o, instruction_o  output  32 each  fetched PC, PC+4, instruction word; these feed the IF/ID register.
REQ-012 The block SHALL have port valid_o  output  1  outputs carry a real instruction; when 0, pc_o, pcplus4_o and instruction_o are 0.

Function
REQ-013 The FSM SHALL have states IDLE (no request), WAIT (request outstanding), DROP (killed request outstanding).
REQ-014 imem_req_o SHALL be 1 exactly in WAIT and DROP; imem_addr_o SHALL equal fetch_pc and stay stable until ack.
REQ-015 Response queue depth Q SHALL be 1, or 2 per REQ-029; IDLE SHALL go to WAIT when queue count < Q.
REQ-016 On ack in WAIT, the block SHALL capture {fetch_pc, imem_rdata_i}, set fetch_pc to fetch_pc+4 mod 2^32, and stay in WAIT if post-ack count < Q, else go to IDLE.
REQ-017 Output load: when valid_o is 0 or stall_i is 0, the output SHALL load the queue head; if the queue is empty it SHALL load the same-cycle ack directly (bypass); if neither exists, valid_o SHALL go to 0.
REQ-018 Latency SHALL be one cycle: ack in cycle N with an empty queue and no stall gives valid_o=1 in cycle N+1.
REQ-019 When stall_i is high and valid_o is 1, all outputs SHALL hold, and an arriving ack SHALL be written to the queue.
REQ-020 The queue SHALL never overflow; the REQ-015 issue rule guarantees this.
REQ-021 pcplus4_o SHALL equal pc_o+4 mod 2^32, so PC 32'hFFFF_FFFC wraps to 0.
REQ-022 redirect_i SHALL take priority over stall_i and ack: fetch_pc := redirect_pc_i, queue flushed, and outputs cleared to 0 (valid_o=0) next cycle.
REQ-023 On redirect, next state SHALL be DROP from WAIT/DROP without same-cycle ack, IDLE with same-cycle ack (data discarded), and IDLE from IDLE.
REQ-024 In DROP, an ack SHALL be discarded and the state SHALL go to IDLE; fetch_pc SHALL not advance.
REQ-025 imem_addr_o in DROP SHALL keep the killed address until ack, so the memory handshake is never broken.

Reset
REQ-026 While rst_i is high at a rising edge: state=IDLE, fetch_pc=RESET_PC, queue empty, valid_o=0, pc_o=pcplus4_o=instruction_o=0.
REQ-027 imem_req_o SHALL be 0 during reset and in the first cycle after release, and SHALL be 1 from the second cycle after release.
REQ-028 Reset mid-operation SHALL abandon any outstanding request; a later ack for it SHALL be ignored while in IDLE.

Configuration
REQ-029 Macro IF_PREFETCH_BUF_EN: when defined, Q=2 and fetching continues through one stalled cycle beyond the held output; when undefined, Q=1 and a stall stops new requests after one buffered response.

Verification
REQ-030 Zero-wait memory (ack same cycle as req), no stall, RESET_PC=0 -> valid_o=1 with pc_o=0,4,8 on consecutive cycles starting at the third cycle after reset release.
REQ-031 Stall held for 5 cycles with pc_o=8 -> pc_o/instruction_o unchanged for 5 cycles, and pc_o=12 on the first unstalled cycle; no instruction lost or duplicated.
REQ-032 Ack delayed 3 cycles, redirect_i with redirect_pc_i=32'h100 in cycle 1 of the wait -> stale ack discarded, next req addr=32'h100, valid_o=0 until that ack.
REQ-033 redirect_i with redirect_pc_i=32'h203 in the same cycle as ack and stall_i=1 -> outputs cleared, fetch resumes at 32'h200.
REQ-034 redirect_pc_i=32'hFFFF_FFFC -> pc_o=32'hFFFF_FFFC, pcplus4_o=0, next fetch address 0.
REQ-035 Build with and without IF_PREFETCH_BUF_EN, 10-cycle stall, zero-wait memory -> at most 2 (undefined) or 3 (defined) acks accepted during the stall; PC order preserved.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word-aligned fetches to instruction memory,
// buffers responses in a small queue, and presents one instruction per cycle
// to the IF/ID register with stall and redirect (branch) handling.
// Optional build macro: IF_PREFETCH_BUF_EN -- deepens the response queue from
// 1 to 2 entries so fetching runs one extra response ahead of a stalled decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] pcplus4_o,
  output logic [31:0] instruction_o,
  output logic        valid_o
);

`ifdef IF_PREFETCH_BUF_EN
  localparam logic [1:0] QL = 2'd2;
`else
  localparam logic [1:0] QL = 2'd1;
`endif
  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

  state_t      r_state;
  logic        r_req;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_addr;
  logic [1:0]  r_cnt;
  logic [31:0] r_qpc  [2];
  logic [31:0] r_qins [2];
  logic        r_valid;
  logic [31:0] r_pc, r_pc4, r_ins;

  logic       w_ack, w_load, w_pop, w_byp, w_push, w_widx;
  logic [1:0] w_cnt_nxt;

  // Only acks for a live (non-killed) request carry a usable instruction.
  assign w_ack     = (r_state == WAIT) && imem_ack_i;
  assign w_load    = !r_valid || !stall_i;
  assign w_pop     = w_load && (r_cnt != 2'd0);
  assign w_byp     = w_load && (r_cnt == 2'd0) && w_ack;
  assign w_push    = w_ack && !w_byp;
  assign w_cnt_nxt = r_cnt - {1'b0, w_pop} + {1'b0, w_push};
  // Write slot = count after the pop: 2->1, 1->0 (popped) or 1 (kept), 0->0.
  assign w_widx    = r_cnt[1] | (r_cnt[0] & ~w_pop);

  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_addr;
  assign valid_o       = r_valid;
  assign pc_o          = r_pc;
  assign pcplus4_o     = r_pc4;
  assign instruction_o = r_ins;

  // Request FSM: issue while the queue has room, kill on redirect, and keep a
  // killed request's address on the bus until memory acknowledges it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_fetch_pc <= RESET_PC_A;
      r_addr     <= RESET_PC_A;
    end else if (redirect_i) begin
      r_fetch_pc <= redirect_pc_i & 32'hFFFF_FFFC;
      if (r_state == IDLE || imem_ack_i) begin
        r_state <= IDLE;
        r_req   <= 1'b0;
      end else begin
        r_state <= DROP;
        r_req   <= 1'b1;
      end
    end else begin
      case (r_state)
        IDLE: if (r_cnt < QL) begin
          r_state <= WAIT;
          r_req   <= 1'b1;
          r_addr  <= r_fetch_pc;
        end
        WAIT: if (imem_ack_i) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
          r_addr     <= r_fetch_pc + 32'd4;
          if (w_cnt_nxt >= QL) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
          end
        end
        DROP: if (imem_ack_i) begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // Response queue: head at slot 0, shift on pop, write behind the survivors.
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      r_cnt <= 2'd0;
    end else begin
      if (w_pop) begin
        r_qpc[0]  <= r_qpc[1];
        r_qins[0] <= r_qins[1];
      end
      if (w_push) begin
        r_qpc[w_widx]  <= r_fetch_pc;
        r_qins[w_widx] <= imem_rdata_i;
      end
      r_cnt <= w_cnt_nxt;
    end
  end

  // Output register: queue head first, else same-cycle bypass, else bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_i) begin
      r_valid <= 1'b0;
      r_pc    <= 32'd0;
      r_pc4   <= 32'd0;
      r_ins   <= 32'd0;
    end else if (w_load) begin
      if (w_pop) begin
        r_valid <= 1'b1;
        r_pc    <= r_qpc[0];
        r_pc4   <= r_qpc[0] + 32'd4;
        r_ins   <= r_qins[0];
      end else if (w_byp) begin
        r_valid <= 1'b1;
        r_pc    <= r_fetch_pc;
        r_pc4   <= r_fetch_pc + 32'd4;
        r_ins   <= imem_rdata_i;
      end else begin
        r_valid <= 1'b0;
        r_pc    <= 32'd0;
        r_pc4   <= 32'd0;
        r_ins   <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by a randomized run with
// random memory latency, stalls, redirects and a mid-run reset. Expected
// values come from an in-order PC scoreboard and a hashed instruction memory.
module tb_if_fetch;
  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef IF_PREFETCH_BUF_EN
  localparam int QD = 2;
`else
  localparam int QD = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_i, stall_i, redirect_i, imem_ack_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, valid_o;
  logic [31:0] imem_addr_o, pc_o, pcplus4_o, instruction_o;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o),
    .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
    .imem_rdata_i(imem_rdata_i), .pc_o(pc_o), .pcplus4_o(pcplus4_o),
    .instruction_o(instruction_o), .valid_o(valid_o)
  );

  int          checks = 0, errors = 0;
  logic [31:0] exp_pc;      // next PC decode should see
  bit          exp_clear;   // redirect last cycle: outputs must be empty
  int          mwait, mlat, lat_lo, lat_hi;
  bit          prev_req, prev_ack, last_ack;
  logic [31:0] prev_addr;
  int          n;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic gen_checks();
    if (!valid_o) chk("empty_zero", pc_o | pcplus4_o | instruction_o, 32'd0);
    if (exp_clear) chkb("redir_clear", valid_o, 1'b0);
    if (valid_o) begin
      chk("pc_order", pc_o, exp_pc);
      chk("pcplus4", pcplus4_o, exp_pc + 32'd4);
      chk("instr", instruction_o, memf(exp_pc));
    end
    if (prev_req && !prev_ack) begin
      chkb("req_hold", imem_req_o, 1'b1);
      chk("addr_hold", imem_addr_o, prev_addr);
    end
    if (imem_req_o) chk("addr_align", {30'd0, imem_addr_o[1:0]}, 32'd0);
  endtask

  // One clock: memory responds to the live request, edge, model update, checks.
  task automatic tick(input bit junk_ack = 1'b0);
    bit v, stl, red, rq, ak;
    logic [31:0] rpc, ad;
    rq = imem_req_o;
    ad = imem_addr_o;
    if (junk_ack) begin
      imem_ack_i = 1'b1; imem_rdata_i = $urandom;
    end else if (rq && mwait >= mlat) begin
      imem_ack_i = 1'b1; imem_rdata_i = memf(ad);
    end else begin
      imem_ack_i = 1'b0; imem_rdata_i = $urandom;
    end
    ak = imem_ack_i; v = valid_o; stl = stall_i; red = redirect_i; rpc = redirect_pc_i;
    @(posedge clk);
    if (red) begin
      exp_pc = rpc & 32'hFFFF_FFFC;
      exp_clear = 1'b1;
    end else begin
      exp_clear = 1'b0;
      if (v && !stl) exp_pc = exp_pc + 32'd4;
    end
    if (rq && ak) begin
      mwait = 0; mlat = $urandom_range(lat_hi, lat_lo);
    end else if (rq) begin
      mwait++;
    end
    prev_req = rq; prev_ack = ak; prev_addr = ad; last_ack = rq && ak;
    @(negedge clk);
    gen_checks();
  endtask

  task automatic do_reset();
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0;
    imem_ack_i = 1'b1; imem_rdata_i = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_req", imem_req_o, 1'b0);
    chkb("rst_valid", valid_o, 1'b0);
    chk("rst_zero", pc_o | pcplus4_o | instruction_o, 32'd0);
    rst_i = 1'b0; imem_ack_i = 1'b0;
    exp_pc = RPC; exp_clear = 1'b0;
    mwait = 0; mlat = $urandom_range(lat_hi, lat_lo);
    prev_req = 1'b0; prev_ack = 1'b0; last_ack = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    imem_ack_i = 1'b0; imem_rdata_i = 32'd0;
    lat_lo = 0; lat_hi = 0;

    // Zero-wait start-up: no request in first cycle, then 0,4,8 back to back.
    do_reset();
    chkb("t1_req_c0", imem_req_o, 1'b0);
    tick(1'b1);                               // stray ack while idle is ignored
    chkb("t1_req_c1", imem_req_o, 1'b1);
    chk("t1_addr_c1", imem_addr_o, RPC);
    chkb("t1_valid_c1", valid_o, 1'b0);
    tick(); chkb("t1_valid_c2", valid_o, 1'b1); chk("t1_pc_c2", pc_o, 32'd0);
    tick(); chk("t1_pc_c3", pc_o, 32'd4);
    tick(); chk("t1_pc_c4", pc_o, 32'd8);

    // Five-cycle stall holding PC 8, then 12 follows.
    stall_i = 1'b1;
    repeat (4) begin
      tick();
      chk("t2_hold_pc", pc_o, 32'd8);
      chk("t2_hold_ins", instruction_o, memf(32'd8));
    end
    stall_i = 1'b0;
    tick();
    chk("t2_next_pc", pc_o, 32'd12);

    // Slow memory, redirect while waiting: stale ack dropped, refetch at 0x100.
    lat_lo = 3; lat_hi = 3;
    do_reset();
    tick();
    chkb("t3_req", imem_req_o, 1'b1);
    chk("t3_addr", imem_addr_o, 32'd0);
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    chkb("t3_kill_req", imem_req_o, 1'b1);
    chk("t3_kill_addr", imem_addr_o, 32'd0);
    for (int k = 0; k < 12 && !(imem_req_o && imem_addr_o == 32'h100); k++) begin
      chkb("t3_no_valid", valid_o, 1'b0);
      tick();
    end
    chkb("t3_new_req", imem_req_o, 1'b1);
    chk("t3_new_addr", imem_addr_o, 32'h100);
    for (int k = 0; k < 12 && !valid_o; k++) tick();
    chk("t3_pc", pc_o, 32'h100);

    // Redirect with same-cycle ack and stall: outputs cleared, resume at 0x200.
    lat_lo = 0; lat_hi = 0;
    for (int k = 0; k < 12 && !(valid_o && imem_req_o && mwait >= mlat); k++) tick();
    chkb("t4_pre_req", imem_req_o, 1'b1);
    stall_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h203;
    tick();
    stall_i = 1'b0; redirect_i = 1'b0;
    chkb("t4_valid", valid_o, 1'b0);
    chk("t4_zero", pc_o | pcplus4_o | instruction_o, 32'd0);
    for (int k = 0; k < 12 && !imem_req_o; k++) tick();
    chk("t4_addr", imem_addr_o, 32'h200);
    for (int k = 0; k < 12 && !valid_o; k++) tick();
    chk("t4_pc", pc_o, 32'h200);

    // Redirect to the top word: PC+4 wraps and the next fetch is address 0.
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    for (int k = 0; k < 12 && !valid_o; k++) tick();
    chk("t5_pc", pc_o, 32'hFFFF_FFFC);
    chk("t5_pc4", pcplus4_o, 32'd0);
    tick();
    for (int k = 0; k < 12 && !valid_o; k++) tick();
    chk("t5_wrap_pc", pc_o, 32'd0);

    // Ten-cycle stall on zero-wait memory: bounded number of accepted acks.
    for (int k = 0; k < 12 && !(valid_o && imem_req_o); k++) tick();
    stall_i = 1'b1; n = 0;
    repeat (10) begin
      tick();
      n += int'(last_ack);
    end
    checks++;
    assert (n <= QD + 1 && n >= 1) else begin
      errors++;
      $error("FAIL t6_stall_acks: observed %0d acks, required 1..%0d", n, QD + 1);
    end
    stall_i = 1'b0;
    repeat (20) tick();

    // Randomized traffic against the scoreboard.
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset();
      stall_i       = ($urandom_range(9, 0) < 3);
      redirect_i    = ($urandom_range(19, 0) == 0);
      redirect_pc_i = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0))
                                                  : $urandom;
      tick();
    end
    stall_i = 1'b0; redirect_i = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
